cordic: RTL and testbench

CORDIC -- requirements
Module: cordic

---
 rtl/cordic_pkg.sv | 44 ++++
 rtl/cordic_stage.sv | 48 ++++
 rtl/cordic.sv | 105 ++++++++++
 tb/tb_cordic.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// CORDIC shared constants and arctangent table.
// Angles are in binary units: a full circle is 2^piw counts.
package cordic_pkg;

  localparam int PW_DEF      = 12;
  localparam int IW_DEF      = 31;
  localparam int OW_DEF      = 32;
  localparam int NSTAGES_DEF = 11;
  localparam int GUARD       = 3;

  // atan(2^-i) with a full circle of 2^32 counts
  function automatic logic [31:0] atan_base(input int i);
    unique case (i)
      0:       atan_base = 32'h2000_0000;
      1:       atan_base = 32'h12e4_051e;
      2:       atan_base = 32'h09fb_385b;
      3:       atan_base = 32'h0511_11d4;
      4:       atan_base = 32'h028b_0d43;
      5:       atan_base = 32'h0145_d7e1;
      6:       atan_base = 32'h00a2_f61e;
      7:       atan_base = 32'h0051_7c55;
      8:       atan_base = 32'h0028_be53;
      9:       atan_base = 32'h0014_5f2f;
      10:      atan_base = 32'h000a_2f98;
      11:      atan_base = 32'h0005_17cc;
      12:      atan_base = 32'h0002_8be6;
      13:      atan_base = 32'h0001_45f3;
      14:      atan_base = 32'h0000_a2f9;
      15:      atan_base = 32'h0000_517d;
      default: atan_base = 32'd683565276 >> i;
    endcase
  endfunction

  // rescale to a 2^piw circle, rounding to nearest
  function automatic logic [63:0] atan_val(input int i, input int piw);
    logic [63:0] t;
    t = {32'd0, atan_base(i)};
    if (piw >= 32)
      atan_val = t << (piw - 32);
    else
      atan_val = (t + (64'd1 << (31 - piw))) >> (32 - piw);
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation, steered by the
// sign of the residual phase.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int WW  = 35,
  parameter int PIW = 16,
  parameter int IDX = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic signed [WW-1:0]  x,
  input  logic signed [WW-1:0]  y,
  input  logic        [PIW-1:0] ph,
  output logic signed [WW-1:0]  xr,
  output logic signed [WW-1:0]  yr,
  output logic        [PIW-1:0] phr
);

  localparam logic [63:0]    A64  = atan_val(IDX, PIW);
  localparam logic [PIW-1:0] ATAN = A64[PIW-1:0];

  logic signed [WW-1:0] xs;
  logic signed [WW-1:0] ys;

  assign xs = x >>> IDX;
  assign ys = y >>> IDX;

  always_ff @(posedge clk) begin
    if (reset) begin
      xr  <= '0;
      yr  <= '0;
      phr <= '0;
    end else if (enable) begin
      if (!ph[PIW-1]) begin
        xr  <= x - ys;
        yr  <= y + xs;
        phr <= ph - ATAN;
      end else begin
        xr  <= x + ys;
        yr  <= y - xs;
        phr <= ph + ATAN;
      end
    end
  end

endmodule

// File: rtl/cordic.sv
// Pipelined rotation-mode CORDIC: quadrant pre-rotation,
// NSTAGES micro-rotations, then round-half-up to OW bits.
module cordic
  import cordic_pkg::*;
#(
  parameter int PW      = PW_DEF,
  parameter int IW      = IW_DEF,
  parameter int OW      = OW_DEF,
  parameter int NSTAGES = NSTAGES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic signed [IW-1:0] i_xval,
  input  logic signed [IW-1:0] i_yval,
  input  logic        [PW-1:0] i_phase,
  output logic signed [OW-1:0] o_xval,
  output logic signed [OW-1:0] o_yval
);

  localparam int WW  = OW + GUARD;
  localparam int PIW = PW + 4;

  logic signed [WW-1:0]  xe;
  logic signed [WW-1:0]  ye;
  logic signed [WW-1:0]  x0;
  logic signed [WW-1:0]  y0;
  logic        [PIW-1:0] p0;
  logic signed [WW-1:0]  xv [0:NSTAGES];
  logic signed [WW-1:0]  yv [0:NSTAGES];
  logic        [PIW-1:0] pv [0:NSTAGES];
  logic signed [WW-1:0]  xf;
  logic signed [WW-1:0]  yf;
  logic                  unused_ok;

  assign xe = {{(WW-IW-GUARD){i_xval[IW-1]}}, i_xval, {GUARD{1'b0}}};
  assign ye = {{(WW-IW-GUARD){i_yval[IW-1]}}, i_yval, {GUARD{1'b0}}};

  // quadrant removed here so the residual is always in [0,90)
  always_ff @(posedge clk) begin
    if (reset) begin
      x0 <= '0;
      y0 <= '0;
      p0 <= '0;
    end else if (enable) begin
      p0 <= {2'b00, i_phase[PW-3:0], 4'b0000};
      unique case (i_phase[PW-1:PW-2])
        2'b00: begin
          x0 <= xe;
          y0 <= ye;
        end
        2'b01: begin
          x0 <= -ye;
          y0 <= xe;
        end
        2'b10: begin
          x0 <= -xe;
          y0 <= -ye;
        end
        2'b11: begin
          x0 <= ye;
          y0 <= -xe;
        end
      endcase
    end
  end

  assign xv[0] = x0;
  assign yv[0] = y0;
  assign pv[0] = p0;

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    cordic_stage #(
      .WW (WW),
      .PIW(PIW),
      .IDX(k)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .enable(enable),
      .x     (xv[k]),
      .y     (yv[k]),
      .ph    (pv[k]),
      .xr    (xv[k+1]),
      .yr    (yv[k+1]),
      .phr   (pv[k+1])
    );
  end

  assign xf = xv[NSTAGES];
  assign yf = yv[NSTAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      o_xval <= '0;
      o_yval <= '0;
    end else if (enable) begin
      o_xval <= xf[WW-1:GUARD] + {{(OW-1){1'b0}}, xf[GUARD-1]};
      o_yval <= yf[WW-1:GUARD] + {{(OW-1){1'b0}}, yf[GUARD-1]};
    end
  end

  assign unused_ok = &{1'b0, xf[GUARD-2:0], yf[GUARD-2:0], pv[NSTAGES]};

endmodule

// File: tb/tb_cordic.sv
// Scoreboard bench for cordic: floating-point rotation model,
// exact checks on reset, latency, enable hold and ordering.
module tb_cordic;

  localparam int  PW   = 12;
  localparam int  IW   = 31;
  localparam int  OW   = 32;
  localparam int  NS   = 11;
  localparam int  LAT  = NS + 2;
  localparam int  XMAX = 32'h3FFF_FFFF;
  localparam real PI   = 3.14159265358979;
  localparam real TOL_SCALE = 1.25;

  typedef struct {
    int unsigned due;
    real         ex;
    real         ey;
    real         tol;
    int          ph;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic signed [IW-1:0] i_xval;
  logic signed [IW-1:0] i_yval;
  logic        [PW-1:0] i_phase;
  logic signed [OW-1:0] o_xval;
  logic signed [OW-1:0] o_yval;

  exp_t        sb[$];
  int unsigned ecnt;
  int          n_chk;
  int          n_fail;
  real         kgain;

  cordic #(
    .PW(PW), .IW(IW), .OW(OW), .NSTAGES(NS)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .i_xval (i_xval),
    .i_yval (i_yval),
    .i_phase(i_phase),
    .o_xval (o_xval),
    .o_yval (o_yval)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input int x, input int y, input int p);
    exp_t m;
    real th, c, s, xr, yr;
    th = 2.0 * PI * $itor(p) / 4096.0;
    c = $cos(th);
    s = $sin(th);
    xr = $itor(x);
    yr = $itor(y);
    m.due = 0;
    m.ph = p;
    m.ex = kgain * (xr * c - yr * s);
    m.ey = kgain * (xr * s + yr * c);
    m.tol = TOL_SCALE * kgain * $sqrt(xr * xr + yr * yr) / 1024.0 + 2.0;
    return m;
  endfunction

  function automatic bit near(input logic signed [OW-1:0] v,
                              input real e, input real tol);
    real d;
    d = $itor(v) - e;
    return (d <= tol) && (d >= -tol);
  endfunction

  task automatic tick(input logic en, input logic rst, input int x,
                      input int y, input int p, input bit push);
    exp_t e;
    enable = en;
    reset = rst;
    i_xval = IW'(x);
    i_yval = IW'(y);
    i_phase = PW'(p);
    if (en && !rst && push) begin
      e = model(x, y, p);
      e.due = ecnt + LAT;
      sb.push_back(e);
    end
    @(posedge clk);
    if (rst) sb.delete();
    else if (en) ecnt++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e;
    tick(1, 1, 12345, 678, 100, 0);
    tick(1, 1, 12345, 678, 100, 0);
    n_chk++;
    if (o_xval !== '0 || o_yval !== '0) begin
      n_fail++;
      $display("FAIL reset got (%0d,%0d) want (0,0)", o_xval, o_yval);
    end
    tick(1, 0, XMAX, 0, 12'h123, 1);
    for (int j = 0; j < LAT - 1; j++) begin
      n_chk++;
      if (o_xval !== '0 || o_yval !== '0) begin
        n_fail++;
        $display("FAIL reset_hold%0d got (%0d,%0d) want (0,0)",
                 j, o_xval, o_yval);
      end
      if (j < LAT - 2) tick(1, 0, 0, 0, 0, 0);
    end
    tick(1, 0, 0, 0, 0, 0);
    n_chk++;
    if (sb.size() == 0 || sb[0].due != ecnt) begin
      n_fail++;
      $display("FAIL reset_first due bookkeeping got %0d want 1",
               sb.size());
    end else begin
      e = sb.pop_front();
      if (!near(o_xval, e.ex, e.tol) || !near(o_yval, e.ey, e.tol)) begin
        n_fail++;
        $display("FAIL reset_first got (%0d,%0d) want (%0.0f,%0.0f)",
                 o_xval, o_yval, e.ex, e.ey);
      end
    end
  endtask

  task automatic test_quadrants();
    int xs[10] = '{XMAX, XMAX, XMAX, XMAX, 0, -32'h4000_0000,
                   32'h1234_5678, 0, 32'h2000_0000, -1};
    int ys[10] = '{0, 0, 0, 0, XMAX, 0, -32'h2345_6789, 0,
                   32'h2000_0000, 1};
    int ps[10] = '{12'h000, 12'h400, 12'h800, 12'hC00, 12'h155,
                   12'h2AB, 12'h9A1, 12'h7FF, 12'hE00, 12'h333};
    exp_t e;
    for (int k = 0; k < 10 + LAT; k++) begin
      if (k < 10) tick(1, 0, xs[k], ys[k], ps[k], 1);
      else tick(1, 0, 0, 0, 0, 0);
      while (sb.size() != 0 && sb[0].due == ecnt) begin
        e = sb.pop_front();
        n_chk++;
        if (!near(o_xval, e.ex, e.tol) || !near(o_yval, e.ey, e.tol)) begin
          n_fail++;
          $display("FAIL quad ph=%03h got (%0d,%0d) want (%0.0f,%0.0f)+-%0.0f",
                   e.ph, o_xval, o_yval, e.ex, e.ey, e.tol);
        end
      end
    end
  endtask

  task automatic test_sweep();
    exp_t e;
    for (int p = 0; p < 4096 + 1; p++) begin
      for (int h = 0; h < NS + 4; h++) begin
        if (p < 4096) tick(1, 0, XMAX, 0, p, h == 0);
        else tick(1, 0, 0, 0, 0, 0);
        while (sb.size() != 0 && sb[0].due == ecnt) begin
          e = sb.pop_front();
          n_chk++;
          if (!near(o_xval, e.ex, e.tol) || !near(o_yval, e.ey, e.tol)) begin
            n_fail++;
            $display("FAIL sweep ph=%03h got (%0d,%0d) want (%0.0f,%0.0f)+-%0.0f",
                     e.ph, o_xval, o_yval, e.ex, e.ey, e.tol);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    tick(1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 16 + LAT; k++) begin
      if (k < 16) tick(1, 0, XMAX, 32'h0100_0000, (k * 12'h101 + 12'h40) & 12'hFFF, 1);
      else tick(1, 0, 0, 0, 0, 0);
      if (k < LAT - 1) begin
        n_chk++;
        if (o_xval !== '0 || o_yval !== '0) begin
          n_fail++;
          $display("FAIL b2b_early%0d got (%0d,%0d) want (0,0)",
                   k, o_xval, o_yval);
        end
      end
      while (sb.size() != 0 && sb[0].due == ecnt) begin
        e = sb.pop_front();
        n_chk++;
        if (!near(o_xval, e.ex, e.tol) || !near(o_yval, e.ey, e.tol)) begin
          n_fail++;
          $display("FAIL b2b ph=%03h got (%0d,%0d) want (%0.0f,%0.0f)+-%0.0f",
                   e.ph, o_xval, o_yval, e.ex, e.ey, e.tol);
        end
      end
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_drain got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_enable_hold();
    exp_t e;
    logic signed [OW-1:0] hx, hy;
    int s;
    s = 0;
    for (int k = 0; k < 20 + 5 + LAT; k++) begin
      if (k >= 16 && k < 21) begin
        tick(0, 0, $urandom_range(1000, 9000), 77, $urandom_range(0, 4095), 1);
        n_chk++;
        if (o_xval !== hx || o_yval !== hy) begin
          n_fail++;
          $display("FAIL hold%0d got (%0d,%0d) want (%0d,%0d)",
                   k - 16, o_xval, o_yval, hx, hy);
        end
      end else begin
        if (s < 20) tick(1, 0, XMAX, 0, (s * 12'h0CD + 12'h011) & 12'hFFF, 1);
        else tick(1, 0, 0, 0, 0, 0);
        s++;
      end
      hx = o_xval;
      hy = o_yval;
      while (sb.size() != 0 && sb[0].due == ecnt) begin
        e = sb.pop_front();
        n_chk++;
        if (!near(o_xval, e.ex, e.tol) || !near(o_yval, e.ey, e.tol)) begin
          n_fail++;
          $display("FAIL en ph=%03h got (%0d,%0d) want (%0.0f,%0.0f)+-%0.0f",
                   e.ph, o_xval, o_yval, e.ex, e.ey, e.tol);
        end
      end
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL en_drain got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    for (int k = 0; k < 10; k++) begin
      tick(1, 0, XMAX, 0, (k * 12'h199) & 12'hFFF, 1);
      while (sb.size() != 0 && sb[0].due == ecnt) begin
        e = sb.pop_front();
        n_chk++;
        if (!near(o_xval, e.ex, e.tol) || !near(o_yval, e.ey, e.tol)) begin
          n_fail++;
          $display("FAIL rmid_pre ph=%03h got (%0d,%0d) want (%0.0f,%0.0f)",
                   e.ph, o_xval, o_yval, e.ex, e.ey);
        end
      end
    end
    tick(1, 1, XMAX, 0, 12'h555, 1);
    n_chk++;
    if (o_xval !== '0 || o_yval !== '0) begin
      n_fail++;
      $display("FAIL rmid_zero got (%0d,%0d) want (0,0)", o_xval, o_yval);
    end
    for (int k = 0; k < LAT + 4 + LAT; k++) begin
      if (k < LAT + 4) tick(1, 0, XMAX, XMAX / 4, (k * 12'h0E3 + 5) & 12'hFFF, 1);
      else tick(1, 0, 0, 0, 0, 0);
      if (k < LAT - 1) begin
        n_chk++;
        if (o_xval !== '0 || o_yval !== '0) begin
          n_fail++;
          $display("FAIL rmid_hold%0d got (%0d,%0d) want (0,0)",
                   k, o_xval, o_yval);
        end
      end
      while (sb.size() != 0 && sb[0].due == ecnt) begin
        e = sb.pop_front();
        n_chk++;
        if (!near(o_xval, e.ex, e.tol) || !near(o_yval, e.ey, e.tol)) begin
          n_fail++;
          $display("FAIL rmid ph=%03h got (%0d,%0d) want (%0.0f,%0.0f)+-%0.0f",
                   e.ph, o_xval, o_yval, e.ex, e.ey, e.tol);
        end
      end
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL rmid_drain got %0d pending want 0", sb.size());
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    ecnt = 0;
    kgain = 1.0;
    for (int i = 0; i < NS; i++)
      kgain = kgain * $sqrt(1.0 + $pow(2.0, -2.0 * i));
    reset = 1'b1;
    enable = 1'b0;
    i_xval = '0;
    i_yval = '0;
    i_phase = '0;
    @(negedge clk);
    test_reset();
    test_quadrants();
    test_back_to_back();
    test_enable_hold();
    test_reset_mid();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
